data_mem_responder: RTL and testbench

//  Data-memory target for the CPU load/store path: the responding end of the core's Memread/Memwrite requests.

---
 rtl/data_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory target with wait states and RV32I byte/half/word access
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EXEC = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;

    logic        wr_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic        f3_bad, misalign, out_range, req_err;
    logic [3:0]  be;
    logic [31:0] wword;
    logic        commit;

    assign word_idx = addr_q[ADDR_WIDTH+1:2];
    assign rd_word  = mem[word_idx];
    assign rd_byte  = rd_word[8*addr_q[1:0] +: 8];
    assign rd_half  = rd_word[16*addr_q[1] +: 16];

    // Checks are prioritised only for documentation; any failure yields the same error response.
    always_comb begin
        if (wr_q)
            f3_bad = f3_q[2] || (f3_q[1:0] == 2'b11);
        else
            f3_bad = (f3_q == 3'b011) || (f3_q == 3'b110) || (f3_q == 3'b111);
        misalign  = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                    ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
        out_range = |addr_q[31:ADDR_WIDTH+2];
        req_err   = f3_bad || misalign || out_range;
    end

    always_comb begin
        case (f3_q)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_data = {24'd0, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_data = {16'd0, rd_half};
            default: load_data = rd_word;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target lanes.
    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_q[1:0];
                wword = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wword = wdata_q;
            end
        endcase
    end

    assign commit = (state == S_EXEC) && !reset && wr_q && !req_err;

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[word_idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && req_valid) begin
            wr_q    <= req_write;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state == S_EXEC) begin
                rsp_err   <= req_err;
                rsp_rdata <= (req_err || wr_q) ? 32'd0 : load_data;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_EXEC;
                    end else begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0)
                    state_nxt = S_EXEC;
                else
                    wait_cnt_nxt = wait_cnt - 4'd1;
            end
            S_EXEC: state_nxt = S_RESP;
            S_RESP: begin
                if (rsp_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder against a byte-level model
module tb_data_mem_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        req_valid0 = 1'b0, req_write0 = 1'b0, rsp_ready0 = 1'b1;
    logic [2:0]  req_funct30 = 3'd0;
    logic [31:0] req_addr0 = 32'd0, req_wdata0 = 32'd0;
    logic        req_ready0, rsp_valid0, rsp_err0, busy0;
    logic [31:0] rsp_rdata0;

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_write(req_write0), .req_funct3(req_funct30), .req_addr(req_addr0),
        .req_wdata(req_wdata0), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .busy(busy0)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [31:0] rdata;
        bit        err;
        int        acc;
    } exp_t;

    exp_t q[$];
    exp_t q0[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   rnd_rdy = 1'b0;
    bit [7:0] ref_mem [4096];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit [31:0] act, input bit [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Byte-addressed little-endian memory; a word index is simply addr/4.
    task automatic ref_access(input bit wr, input bit [2:0] f3, input bit [31:0] a,
                              input bit [31:0] wd, output bit [31:0] rd, output bit err);
        int  sz;
        bit  legal;
        legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz    = 1 << f3[1:0];
        err   = !legal || ((a % sz) != 0) || (a >= 32'd4096);
        rd    = 32'd0;
        if (!err) begin
            if (wr) begin
                for (int i = 0; i < sz; i++) ref_mem[a + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < sz; i++) rd |= 32'(ref_mem[a + i]) << (8 * i);
                if (f3 < 3'd4 && sz < 4 && rd[8*sz-1]) rd |= 32'hFFFF_FFFF << (8 * sz);
            end
        end
    endtask

    task automatic send(input bit wr, input bit [2:0] f3, input bit [31:0] a,
                        input bit [31:0] wd, input bit track);
        exp_t e;
        bit   done = 1'b0;
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                if (track) begin
                    ref_access(wr, f3, a, wd, e.rdata, e.err);
                    e.acc = cyc + 1;
                    q.push_back(e);
                end
                done = 1'b1;
            end
            @(posedge clk); #1;
            if (rnd_rdy) rsp_ready = 1'($urandom_range(0, 1));
        end
        req_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q.size() != 0 || !req_ready); i++) begin
            @(posedge clk); #1;
        end
        check("drain_queue_empty", 32'(q.size()), 32'd0);
    endtask

    bit        pv = 1'b0, phs = 1'b0, perr = 1'b0;
    bit [31:0] prd = 32'd0;
    exp_t      mon_e;

    always @(negedge clk) begin
        if (reset) begin
            pv = 1'b0;
            phs = 1'b0;
        end else begin
            if (rsp_valid) begin
                check("req_ready_low_in_resp", 32'(req_ready), 32'd0);
                if (!pv) begin
                    if (q.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
                    else check("rsp_latency", 32'(cyc - q[0].acc), 32'(W + 1));
                end else if (!phs) begin
                    check("rdata_stable", rsp_rdata, prd);
                    check("err_stable", 32'(rsp_err), 32'(perr));
                end
                if (rsp_ready && q.size() != 0) begin
                    mon_e = q.pop_front();
                    check("rsp_rdata", rsp_rdata, mon_e.rdata);
                    check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                end
            end
            pv  = rsp_valid;
            phs = rsp_valid && rsp_ready;
            prd = rsp_rdata;
            perr = rsp_err;
        end
    end

    bit   pv0 = 1'b0;
    exp_t mon0_e;

    always @(negedge clk) begin
        if (!reset) begin
            if (rsp_valid0 && !pv0) begin
                if (q0.size() == 0) begin
                    check("unexpected_rsp0", 32'd1, 32'd0);
                end else begin
                    mon0_e = q0.pop_front();
                    check("rsp_latency0", 32'(cyc - mon0_e.acc), 32'd1);
                    check("rsp_rdata0", rsp_rdata0, mon0_e.rdata);
                    check("rsp_err0", 32'(rsp_err0), 32'(mon0_e.err));
                end
            end
            pv0 = rsp_valid0;
        end else begin
            pv0 = 1'b0;
        end
    end

    bit [31:0] b2b_addr [5] = '{32'h4, 32'h4, 32'h6, 32'h5, 32'h4};
    bit        b2b_wr   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bit [2:0]  b2b_f3   [5] = '{3'd2, 3'd2, 3'd1, 3'd4, 3'd2};
    bit [31:0] b2b_exp  [5] = '{32'h0, 32'hCAFEF00D, 32'hFFFFCAFE, 32'h000000F0, 32'hCAFEF00D};

    initial begin
        exp_t e0;
        int   prev_acc;
        bit   ok;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_busy0", 32'(busy0), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int w = 0; w < 16; w++) send(1'b1, 3'd2, 32'(w * 4), $urandom, 1'b1);

        send(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1);
        send(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
        send(1'b1, 3'd0, 32'h13, 32'h80, 1'b1);
        send(1'b0, 3'd0, 32'h13, 32'h0, 1'b1);
        send(1'b0, 3'd4, 32'h13, 32'h0, 1'b1);
        send(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
        send(1'b0, 3'd1, 32'h11, 32'h0, 1'b1);
        send(1'b1, 3'd2, 32'h1000, 32'h55AA55AA, 1'b1);
        send(1'b0, 3'd2, 32'h0, 32'h0, 1'b1);
        drain();

        // Response held for five cycles, then a single-cycle consume pulse.
        rsp_ready = 1'b0;
        send(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = rsp_valid;
        end
        check("hold_rsp_seen", 32'(ok), 32'd1);
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("idle_after_consume", 32'(req_ready), 32'd1);
        check("valid_drop_after_consume", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1 rsp_ready = 1'b1;

        // Reset in WAIT abandons the store.
        send(1'b1, 3'd2, 32'h20, 32'h12345678, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_reset_no_rsp", 32'(rsp_valid), 32'd0);
            check("mid_reset_ready", 32'(req_ready), 32'd1);
        end
        @(posedge clk); #1;
        send(1'b0, 3'd2, 32'h20, 32'h0, 1'b1);
        drain();

        rnd_rdy = 1'b1;
        for (int n = 0; n < 80; n++) begin
            bit [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 63));
            send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'b1);
        end
        rnd_rdy = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // Zero wait states: back-to-back with rsp_ready tied high.
        prev_acc = 0;
        req_valid0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_write0 = b2b_wr[k]; req_funct30 = b2b_f3[k]; req_addr0 = b2b_addr[k];
            req_wdata0 = 32'hCAFEF00D;
            ok = 1'b0;
            for (int i = 0; i < 10 && !ok; i++) begin
                @(negedge clk);
                ok = req_ready0;
                if (!ok) begin @(posedge clk); #1; end
            end
            check("b2b_accept", 32'(ok), 32'd1);
            e0.rdata = b2b_exp[k];
            e0.err   = 1'b0;
            e0.acc   = cyc + 1;
            q0.push_back(e0);
            if (k > 0) check("b2b_interval", 32'(e0.acc - prev_acc), 32'd3);
            prev_acc = e0.acc;
            @(posedge clk); #1;
        end
        req_valid0 = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("b2b_queue_empty", 32'(q0.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
